// File: rtl/sa_requant.sv
// sa_requant: requantizes a finished 4x4 int32 accumulator tile to int8.
// The 16 accumulators and the per-column config are captured on start. Rows
// then flow one per cycle through bias/shift, SRDHM and rounding/clamp
// stages. The packed tile is held on a valid/ready output until accepted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; only state in which start is accepted
// RUN     | rows 0..3 issued, pipeline draining into q_out
// HOLD    | tile complete, out_valid high until out_ready
module sa_requant #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [16*ACC_W-1:0]  acc_in,
  input  logic [4*ACC_W-1:0]   bias_in,
  input  logic [4*ACC_W-1:0]   mult_in,
  input  logic [4*SHIFT_W-1:0] shift_in,
  input  logic [8:0]           output_offset,
  input  logic [OUT_W-1:0]     act_min,
  input  logic [OUT_W-1:0]     act_max,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [16*OUT_W-1:0]  q_out,
  output logic                 busy
);

  localparam int ROW_W = 4 * ACC_W;
  localparam int ROW_Q = 4 * OUT_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 issuing_q, issuing_d;
  logic [1:0]           row_cnt_q, row_cnt_d;
  logic                 capture;

  logic [16*ACC_W-1:0]  acc_q;
  logic [4*ACC_W-1:0]   bias_q, mult_q;
  logic [4*SHIFT_W-1:0] shift_q;
  logic [8:0]           offset_q;
  logic [OUT_W-1:0]     min_q, max_q;

  logic                 iss_v_q, s1_v_q, s2_v_q;
  logic [1:0]           iss_row_q, s1_row_q, s2_row_q;
  logic [ROW_W-1:0]     iss_acc_q, s1_x_q, s2_y_q;
  logic [ROW_W-1:0]     s1_x_d, s2_y_d;
  logic [ROW_Q-1:0]     row_q_d;
  logic [16*OUT_W-1:0]  q_out_q;

  // Bias add and optional left shift, both wrapping at 32 bits.
  function automatic logic [31:0] f_s1(input logic [31:0] acc,
                                       input logic [31:0] bias,
                                       input logic [SHIFT_W-1:0] sh);
    logic [31:0] sum;
    sum = acc + bias;
    if (!sh[SHIFT_W-1] && (sh != '0)) sum = sum << sh[4:0];
    return sum;
  endfunction

  // Saturating rounding doubling high multiply.
  function automatic logic [31:0] f_srdhm(input logic [31:0] x,
                                          input logic [31:0] m);
    logic signed [63:0] xs, ms, p, t;
    logic [31:0] res;
    xs = {{32{x[31]}}, x};
    ms = {{32{m[31]}}, m};
    p  = xs * ms;
    t  = p + (p[63] ? -64'sd1073741823 : 64'sd1073741824);
    // bias negative values so the arithmetic shift truncates toward zero
    if (t[63]) t = t + 64'sd2147483647;
    res = t[62:31];
    if ((x == 32'h8000_0000) && (m == 32'h8000_0000)) res = 32'h7FFF_FFFF;
    return res;
  endfunction

  // Rounding right shift, zero-point add and clamp to [lo, hi].
  function automatic logic [7:0] f_s3(input logic [31:0] y,
                                      input logic [SHIFT_W-1:0] sh,
                                      input logic [8:0] off,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
    logic [4:0]         e;
    logic [31:0]        mask, rem, thr;
    logic signed [31:0] ys, sr;
    logic signed [33:0] v, lo_s, hi_s;
    logic [7:0]         res;
    e    = sh[SHIFT_W-1] ? (~sh[4:0] + 5'd1) : 5'd0;
    mask = (32'd1 << e) - 32'd1;
    rem  = y & mask;
    thr  = (mask >> 1) + {31'd0, y[31]};
    ys   = y;
    sr   = ys >>> e;
    v    = {{2{sr[31]}}, sr} + {33'd0, (rem > thr)} + {{25{off[8]}}, off};
    lo_s = {{26{lo[7]}}, lo};
    hi_s = {{26{hi[7]}}, hi};
    if (v < lo_s)      res = lo;
    else if (v > hi_s) res = hi;
    else               res = v[7:0];
    return res;
  endfunction

  // Sequencing: accept start in IDLE, issue four rows, wait for the last row.
  always_comb begin
    state_d   = state_q;
    issuing_d = issuing_q;
    row_cnt_d = row_cnt_q;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          issuing_d = 1'b1;
          row_cnt_d = 2'd0;
          capture   = 1'b1;
        end
      end
      ST_RUN: begin
        if (issuing_q) begin
          row_cnt_d = row_cnt_q + 2'd1;
          if (row_cnt_q == 2'd3) issuing_d = 1'b0;
        end
        if (s2_v_q && (s2_row_q == 2'd3)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-column arithmetic of the three stages for the row in each stage.
  always_comb begin
    s1_x_d  = '0;
    s2_y_d  = '0;
    row_q_d = '0;
    for (int c = 0; c < 4; c++) begin
      s1_x_d[32*(3-c) +: 32] = f_s1(iss_acc_q[32*(3-c) +: 32], bias_q[32*(3-c) +: 32],
                                    shift_q[SHIFT_W*(3-c) +: SHIFT_W]);
      s2_y_d[32*(3-c) +: 32] = f_srdhm(s1_x_q[32*(3-c) +: 32], mult_q[32*(3-c) +: 32]);
      row_q_d[8*(3-c) +: 8]  = f_s3(s2_y_q[32*(3-c) +: 32], shift_q[SHIFT_W*(3-c) +: SHIFT_W],
                                    offset_q, min_q, max_q);
    end
  end

  // Control state, pipeline valids and the output tile register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      issuing_q <= 1'b0;
      row_cnt_q <= 2'd0;
      iss_v_q   <= 1'b0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      q_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      issuing_q <= issuing_d;
      row_cnt_q <= row_cnt_d;
      iss_v_q   <= (state_q == ST_RUN) && issuing_q;
      s1_v_q    <= iss_v_q;
      s2_v_q    <= s1_v_q;
      if (s2_v_q) q_out_q[ROW_Q*(3-int'(s2_row_q)) +: ROW_Q] <= row_q_d;
    end
  end

  // Captured tile/config and pipeline data; qualified by the valids above.
  always_ff @(posedge clk) begin
    if (capture) begin
      acc_q    <= acc_in;
      bias_q   <= bias_in;
      mult_q   <= mult_in;
      shift_q  <= shift_in;
      offset_q <= output_offset;
      min_q    <= act_min;
      max_q    <= act_max;
    end
    iss_acc_q <= acc_q[ROW_W*(3-int'(row_cnt_q)) +: ROW_W];
    iss_row_q <= row_cnt_q;
    s1_x_q    <= s1_x_d;
    s1_row_q  <= iss_row_q;
    s2_y_q    <= s2_y_d;
    s2_row_q  <= s1_row_q;
  end

  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign q_out     = q_out_q;

endmodule
